// File: rtl/data_mem_pkg.sv
// Shared MEM-stage definitions: access-command encodings, error cause codes,
// the captured-error record and the error classifier used by data_mem.
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned ERR_W  = 2;

  // MEM-stage access commands
  localparam logic [CMD_W-1:0] MEM_IDLE    = 2'b00;
  localparam logic [CMD_W-1:0] MEM_LOAD    = 2'b01;
  localparam logic [CMD_W-1:0] MEM_STORE   = 2'b10;
  localparam logic [CMD_W-1:0] MEM_ILLEGAL = 2'b11;

  // Error causes
  localparam logic [ERR_W-1:0] ERR_NONE     = 2'b00;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 2'b01;
  localparam logic [ERR_W-1:0] ERR_RANGE    = 2'b10;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL  = 2'b11;

  // First-error record held until reset
  typedef struct packed {
    logic              flag;
    logic [ERR_W-1:0]  code;
    logic [ADDR_W-1:0] addr;
  } err_rec_t;

  // Priority: illegal command > out of range > misaligned; idle never errs
  function automatic logic [ERR_W-1:0] classify_err(
    input logic [CMD_W-1:0] cmd,
    input logic             misaligned,
    input logic             out_of_range
  );
    logic [ERR_W-1:0] code;
    code = ERR_NONE;
    if (cmd == MEM_ILLEGAL) begin
      code = ERR_ILLEGAL;
    end else if (cmd != MEM_IDLE) begin
      if (out_of_range) begin
        code = ERR_RANGE;
      end else if (misaligned) begin
        code = ERR_MISALIGN;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/data_mem_sat_counter.sv
// Saturating up-counter: counts i_inc pulses and holds at all-ones.
// Ports: clk, reset_n (async active-low), i_inc (count enable),
//        o_count (current count, registered).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Increment only while below all-ones so the count never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_mem.sv
// MEM-stage data memory: word-addressed array with zero-latency loads,
// clocked stores, sticky first-error capture and saturating access counters.
// Ports: clk, reset_n (async active-low), mem_ctrl_input (command),
//        address (byte address), w_data (store data), read_data (load data,
//        combinational), err_flag/err_code/err_addr (first error, sticky),
//        load_cnt/store_cnt (legal access counts, saturating).
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  mem_ctrl_input,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] read_data,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  err_rec_t          r_err;

  logic              w_misaligned;
  logic              w_out_of_range;
  logic [ERR_W-1:0]  w_err_code;
  logic              w_load_ok;
  logic              w_store_ok;
  logic [IDX_W-1:0]  w_idx;

  // Access qualification; out of range means any byte-address bit above the array is set
  assign w_misaligned   = (address[1:0] != 2'b00);
  assign w_out_of_range = (address[ADDR_W-1:IDX_W+2] != '0);
  assign w_err_code     = classify_err(mem_ctrl_input, w_misaligned, w_out_of_range);
  assign w_load_ok      = (mem_ctrl_input == MEM_LOAD)  && (w_err_code == ERR_NONE);
  assign w_store_ok     = (mem_ctrl_input == MEM_STORE) && (w_err_code == ERR_NONE);
  assign w_idx          = address[IDX_W+1:2];

  // Zero-latency load path; anything but a legal load returns zero
  assign read_data = w_load_ok ? r_mem[w_idx] : '0;

  // Array write; reset only blocks the write, contents are never cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (w_store_ok) begin
      r_mem[w_idx] <= w_data;
    end
  end

  // Capture the first error after reset and hold it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= '0;
    end else if (!r_err.flag && (w_err_code != ERR_NONE)) begin
      r_err.flag <= 1'b1;
      r_err.code <= w_err_code;
      r_err.addr <= address;
    end
  end

  assign err_flag = r_err.flag;
  assign err_code = r_err.code;
  assign err_addr = r_err.addr;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_load_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_load_ok),
    .o_count (load_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_store_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_store_ok),
    .o_count (store_cnt)
  );

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: each driven cycle pushes the expected load data
// and pre-edge status; a negedge monitor pops and compares. A second instance
// with 4-bit counters checks saturation.
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] read_data;
  logic        err_flag;
  logic [1:0]  err_code;
  logic [31:0] err_addr;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;

  logic [31:0] s_read_data;
  logic        s_err_flag;
  logic [1:0]  s_err_code;
  logic [31:0] s_err_addr;
  logic [3:0]  s_load_cnt;
  logic [3:0]  s_store_cnt;

  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_ctrl_input(cmd), .address(addr),
    .w_data(wdata), .read_data(read_data), .err_flag(err_flag),
    .err_code(err_code), .err_addr(err_addr), .load_cnt(load_cnt),
    .store_cnt(store_cnt)
  );

  data_mem #(.DEPTH_WORDS(DEPTH), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .mem_ctrl_input(cmd), .address(addr),
    .w_data(wdata), .read_data(s_read_data), .err_flag(s_err_flag),
    .err_code(s_err_code), .err_addr(s_err_addr), .load_cnt(s_load_cnt),
    .store_cnt(s_store_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [logic [31:0]];
  logic        m_flag;
  logic [1:0]  m_code;
  logic [31:0] m_addr;
  int          m_lcnt, m_scnt, m_lsat;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        flag;
    logic [1:0]  code;
    logic [31:0] eaddr;
    int          lcnt;
    int          scnt;
    int          lsat;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_reset();
    m_flag = 1'b0; m_code = 2'b00; m_addr = 32'h0;
    m_lcnt = 0; m_scnt = 0; m_lsat = 0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] rd);
    exp_t e;
    e.tag = tag; e.rd = rd; e.flag = m_flag; e.code = m_code; e.eaddr = m_addr;
    e.lcnt = m_lcnt; e.scnt = m_scnt; e.lsat = m_lsat;
    exp_q.push_back(e);
  endtask

  // Drive one access at posedge+1, record expectations, advance the model past the edge
  task automatic drive(input string tag, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d);
    logic [1:0]  ec;
    logic        legal;
    logic [31:0] rd;
    cmd = c; addr = a; wdata = d;
    if (c == 2'b11)                ec = 2'b11;
    else if (c == 2'b00)           ec = 2'b00;
    else if (a >= 32'(4 * DEPTH))  ec = 2'b10;
    else if (a[1:0] != 2'b00)      ec = 2'b01;
    else                           ec = 2'b00;
    legal = (c == 2'b01 || c == 2'b10) && (ec == 2'b00);
    rd = (legal && c == 2'b01) ? m_mem[a >> 2] : 32'h0;
    push_exp(tag, rd);
    if (legal && c == 2'b10) begin
      m_mem[a >> 2] = d;
      m_scnt++;
    end
    if (legal && c == 2'b01) begin
      m_lcnt++;
      if (m_lsat < 15) m_lsat++;
    end
    if (ec != 2'b00 && !m_flag) begin
      m_flag = 1'b1; m_code = ec; m_addr = a;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status_zero(input string tag);
    chk({tag, "/flag"},  32'(err_flag),   32'h0);
    chk({tag, "/code"},  32'(err_code),   32'h0);
    chk({tag, "/eaddr"}, err_addr,        32'h0);
    chk({tag, "/lcnt"},  32'(load_cnt),   32'h0);
    chk({tag, "/scnt"},  32'(store_cnt),  32'h0);
    chk({tag, "/lsat"},  32'(s_load_cnt), 32'h0);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "/rd"},    read_data,          e.rd);
      chk({e.tag, "/flag"},  32'(err_flag),      32'(e.flag));
      chk({e.tag, "/code"},  32'(err_code),      32'(e.code));
      chk({e.tag, "/eaddr"}, err_addr,           e.eaddr);
      chk({e.tag, "/lcnt"},  32'(load_cnt),      32'(e.lcnt));
      chk({e.tag, "/scnt"},  32'(store_cnt),     32'(e.scnt));
      chk({e.tag, "/lsat"},  32'(s_load_cnt),    32'(e.lsat));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd = 2'b00; addr = 32'h0; wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_status_zero("reset");
    reset_n = 1'b1;

    // Store then load back; idle with a misaligned address must not err
    drive("t1_st10",   2'b10, 32'h10, 32'hDEADBEEF);
    drive("t1_ld10",   2'b01, 32'h10, 32'h0);
    drive("t1_idle3",  2'b00, 32'h3,  32'h0);
    drive("t1_st20",   2'b10, 32'h20, 32'h12345678);
    drive("t1_ld20",   2'b01, 32'h20, 32'h0);
    drive("t1_st3fc",  2'b10, 32'hFFC, 32'hCAFEF00D);
    drive("t1_ld3fc",  2'b01, 32'hFFC, 32'h0);

    // Misaligned store: no write, first error captured
    drive("t2_st12",   2'b10, 32'h12, 32'hAAAAAAAA);
    drive("t2_ld10",   2'b01, 32'h10, 32'h0);
    drive("t2_idle",   2'b00, 32'h0,  32'h0);

    // Reset asserted with a store pending: status clears at once, store dropped
    cmd = 2'b10; addr = 32'h10; wdata = 32'h11111111; reset_n = 1'b0;
    model_reset();
    #1;
    chk_status_zero("t5_async");
    push_exp("t5_rst", 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive("t5_ld10",   2'b01, 32'h10, 32'h0);
    drive("t5_ld20",   2'b01, 32'h20, 32'h0);

    // Out-of-range load then illegal command: first cause (range) sticks
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive("t3_ld1000", 2'b01, 32'h1000, 32'h0);
    drive("t3_ill2",   2'b11, 32'h2,    32'h0);
    drive("t3_st1004", 2'b10, 32'h1004, 32'h55555555);
    drive("t3_stff",   2'b10, 32'hFFFF_FFF0, 32'h66666666);
    drive("t3_ld3fc",  2'b01, 32'hFFC,  32'h0);
    drive("t3_idle",   2'b00, 32'h0,    32'h0);

    // Saturation: 17 legal loads on a 4-bit counter
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive($sformatf("t4_ld%0d", i), 2'b01, 32'h20, 32'h0);
    end
    drive("t4_idle",   2'b00, 32'h0, 32'h0);
    drive("t4_end",    2'b00, 32'h0, 32'h0);

    chk("q_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the data array (power of two, min 16).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port mem_ctrl_input, input, 2, meaning the MEM-stage access command: 00 idle, 01 load, 10 store, 11 illegal.
REQ-006 The block SHALL have port address, input, 32, meaning the byte address from the MEM stage.
REQ-007 The block SHALL have port w_data, input, 32, meaning the store data.
REQ-008 The block SHALL have port read_data, output, 32, meaning the load data returned to the MEM stage in the same cycle.
REQ-009 The block SHALL have port err_flag, output, 1, meaning a sticky access-error indication.
REQ-010 The block SHALL have port err_code, output, 2, meaning the first error cause: 01 misaligned, 10 out of range, 11 illegal command.
REQ-011 The block SHALL have port err_addr, output, 32, meaning the byte address of the first erroneous access.
REQ-012 The block SHALL have port load_cnt, output, CNT_W, meaning the count of completed legal loads.
REQ-013 The block SHALL have port store_cnt, output, CNT_W, meaning the count of completed legal stores.

Function
REQ-014 An access SHALL be legal only when the command is 01 or 10, address[1:0]==0 and address < 4*DEPTH_WORDS.
REQ-015 Word index SHALL be address[2+log2(DEPTH_WORDS)-1:2].
REQ-016 A legal load SHALL drive read_data combinationally from the array, with zero cycles of latency.
REQ-017 read_data SHALL be 32'h0 for idle, store, illegal or erroneous commands.
REQ-018 A legal store SHALL write w_data to the array at the rising clk edge; a load of the same word in the next cycle returns the new data.
REQ-019 An illegal or erroneous store SHALL NOT modify the array.
REQ-020 Error classification priority SHALL be illegal command (11) > out of range (10) > misaligned (01); idle (00) never errs.
REQ-021 On the first error after reset, err_flag, err_code and err_addr SHALL be captured at the clock edge; later errors SHALL NOT overwrite them.
REQ-022 load_cnt and store_cnt SHALL increment by 1 per legal access and saturate at all-ones, with no wrap-around.
REQ-023 An erroneous access SHALL increment no counter.

Reset
REQ-024 On reset_n low, err_flag SHALL be 0, err_code 2'b00, err_addr 32'h0, load_cnt 0 and store_cnt 0, asynchronously.
REQ-025 Array contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-026 A store coinciding with reset_n low SHALL NOT be written; reset released mid-cycle takes effect from the next rising edge.

Structure
REQ-027 The shared pipeline package SHALL hold the mem_ctrl encodings (MEM_IDLE, MEM_LOAD, MEM_STORE, MEM_ILLEGAL) and the error codes (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL).
REQ-028 The block SHALL instantiate twice one sub-module, sat_counter (parameter width, inc input, saturating count output), for load_cnt and store_cnt.

Verification
REQ-029 Directed test 1: store 10/addr 0x10/data 0xDEADBEEF, then load 01/addr 0x10 -> read_data 0xDEADBEEF in the load cycle; store_cnt=1 and load_cnt=1.
REQ-030 Directed test 2: store to addr 0x12 -> word 0x10 unchanged, err_flag=1, err_code=01, err_addr=0x12, store_cnt unchanged.
REQ-031 Directed test 3: load addr 0x1000 (DEPTH_WORDS=1024), then command 11 at addr 0x2 -> read_data 0 both cycles, err_code stays 10, err_addr stays 0x1000.
REQ-032 Directed test 4: CNT_W=4, 17 legal loads -> load_cnt reads 15 after the 15th load and stays 15.
REQ-033 Directed test 5: reset_n pulsed low mid-sequence with a store pending -> all status outputs zero immediately; stored word not updated; previously written words retained.
